// File: rtl/pixel_frame_buffer.sv
// pixel_frame_buffer: double-buffered pixel store between the ray tracer
// (writer) and the VGA scanner (reader). Banks swap only at the start of
// vertical blanking after the tracer has reported a finished frame.
// Optional feature macro: FB_DOUBLE_BUFFER_EN (undefined = single shared bank,
// front_sel held at 0, FSM and frame_count still active).
module pixel_frame_buffer #(
  parameter int ROW_WIDTH  = 6,
  parameter int COL_WIDTH  = 7,
  parameter int ROWS       = 60,
  parameter int COLS       = 80,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [COL_WIDTH-1:0]  wr_col,
  input  logic [ROW_WIDTH-1:0]  wr_row,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  frame_done,
  output logic                  wr_ready,
  input  logic                  vsync_start,
  input  logic [COL_WIDTH-1:0]  rd_col,
  input  logic [ROW_WIDTH-1:0]  rd_row,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  front_sel,
  output logic                  swap_pending,
  output logic [7:0]            frame_count
);

  localparam int ADDR_W = COL_WIDTH + ROW_WIDTH;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic {FILL, WAIT_SWAP} state_t;

  state_t                state_q, state_d;
  logic                  front_sel_q, front_sel_d;
  logic [7:0]            frame_count_q, frame_count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic              wr_in_range, rd_in_range, wr_accept;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  assign wr_addr     = {wr_col, wr_row};
  assign rd_addr     = {rd_col, rd_row};
  assign wr_in_range = (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
  assign rd_in_range = (32'(rd_col) < COLS) && (32'(rd_row) < ROWS);
  assign wr_accept   = wr_en && wr_ready && wr_in_range;

  // Next-state, swap and flow-control outputs derived from the current state.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d       = state_q;
    front_sel_d   = front_sel_q;
    frame_count_d = frame_count_q;
    wr_ready      = 1'b0;
    swap_pending  = 1'b0;
    case (state_q)
      FILL: begin
        wr_ready = 1'b1;
        // vsync_start is ignored here; a frame must be finished first.
        if (frame_done) state_d = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        swap_pending = 1'b1;
        if (vsync_start) begin
          state_d       = FILL;
          frame_count_d = frame_count_q + 8'd1;
`ifdef FB_DOUBLE_BUFFER_EN
          front_sel_d   = ~front_sel_q;
`endif
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State, bank select and frame counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q       <= FILL;
      front_sel_q   <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      front_sel_q   <= front_sel_d;
      frame_count_q <= frame_count_d;
    end
  end

`ifdef FB_DOUBLE_BUFFER_EN
  logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

  // Writer fills the back bank; reader sees the front bank selected pre-edge.
  always_ff @(posedge clk) begin
    // NOTE: the pixel arrays are deliberately not reset, which keeps them
    // mappable onto block RAM; only the read register is cleared.
    if (wr_accept) mem_q[~front_sel_q][wr_addr] <= wr_data;
  end

  // Out-of-range reads return black instead of aliased storage.
  always_comb begin
    rd_data_d = rd_in_range ? mem_q[front_sel_q][rd_addr] : '0;
  end
`else
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Single shared bank; a same-address read in the write cycle sees old data.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_addr] <= wr_data;
  end

  // Out-of-range reads return black instead of aliased storage.
  always_comb begin
    rd_data_d = rd_in_range ? mem_q[rd_addr] : '0;
  end
`endif

  // One-cycle registered read port.
  always_ff @(posedge clk) begin
    if (!rst) rd_data_q <= '0;
    else      rd_data_q <= rd_data_d;
  end

  assign rd_data     = rd_data_q;
  assign front_sel   = front_sel_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Self-checking bench for pixel_frame_buffer. A behavioural model tracks the
// banks, FSM, front bank and frame counter; expected read data is queued when
// a read address is driven and popped once the registered output appears.
module tb_pixel_frame_buffer;

`ifdef FB_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [6:0]  wr_col = '0;
  logic [5:0]  wr_row = '0;
  logic [11:0] wr_data = '0;
  logic        frame_done = 1'b0;
  logic        wr_ready;
  logic        vsync_start = 1'b0;
  logic [6:0]  rd_col = '0;
  logic [5:0]  rd_row = '0;
  logic [11:0] rd_data;
  logic        front_sel;
  logic        swap_pending;
  logic [7:0]  frame_count;

  int checks = 0;
  int failures = 0;

  // Model state.
  logic [11:0] m_mem [2][8192];
  bit          m_fill = 1'b1;
  bit          m_front = 1'b0;
  logic [7:0]  m_count = 8'd0;
  logic [11:0] exp_q [$];
  logic [11:0] exp;

  pixel_frame_buffer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row),
    .wr_data(wr_data), .frame_done(frame_done), .wr_ready(wr_ready),
    .vsync_start(vsync_start), .rd_col(rd_col), .rd_row(rd_row),
    .rd_data(rd_data), .front_sel(front_sel), .swap_pending(swap_pending),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; model advances with the DUT, read expectation queued.
  task automatic drive(input bit we, input int wc, input int wrw, input logic [11:0] wd,
                       input bit fd, input bit vs, input int rc, input int rr, input bit chk);
    logic [12:0] ra, wa;
    int rb, wb;
    wr_en = we; wr_col = 7'(wc); wr_row = 6'(wrw); wr_data = wd;
    frame_done = fd; vsync_start = vs; rd_col = 7'(rc); rd_row = 6'(rr);
    ra = {7'(rc), 6'(rr)};
    wa = {7'(wc), 6'(wrw)};
    rb = DB ? int'(m_front) : 0;
    wb = DB ? int'(!m_front) : 0;
    if (chk) exp_q.push_back((rc < 80 && rr < 60) ? m_mem[rb][ra] : 12'h000);
    if (we && m_fill && wc < 80 && wrw < 60) m_mem[wb][wa] = wd;
    if (m_fill && fd) m_fill = 1'b0;
    else if (!m_fill && vs) begin
      m_fill = 1'b1;
      m_count = m_count + 8'd1;
      if (DB) m_front = ~m_front;
    end
    @(posedge clk); #1;
    wr_en = 1'b0; frame_done = 1'b0; vsync_start = 1'b0;
  endtask

  task automatic swap();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic apply_reset(input int rc, input int rr);
    rst = 1'b0; rd_col = 7'(rc); rd_row = 6'(rr);
    frame_done = 1'b0; vsync_start = 1'b0; wr_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_fill = 1'b1; m_front = 1'b0; m_count = 8'd0;
  endtask

  // Give every location the bench reads a known value in both banks.
  task automatic prefill();
    int cols[9] = '{0, 3, 5, 79, 10, 11, 12, 13, 9};
    int rows[9] = '{0, 2, 5, 59, 7, 7, 7, 7, 7};
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 9; k++) drive(1, cols[k], rows[k], 12'h000, 0, 0, 0, 0, 0);
      swap();
    end
  endtask

  task automatic test_reset();
    apply_reset(3, 2);
    checks++; if (rd_data !== 12'h000) begin failures++; $display("FAIL reset_rd_data: got %h want 000", rd_data); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    checks++; if (swap_pending !== 1'b0) begin failures++; $display("FAIL reset_swap_pending: got %b want 0", swap_pending); end
    checks++; if (front_sel !== 1'b0) begin failures++; $display("FAIL reset_front_sel: got %b want 0", front_sel); end
    checks++; if (frame_count !== 8'd0) begin failures++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
  endtask

  task automatic test_basic_write_read();
    drive(1, 3, 2, 12'hF0F, 0, 0, 3, 2, 1);
    exp = exp_q.pop_front();
    checks++; if (rd_data !== exp) begin failures++; $display("FAIL basic_pre_swap_rd: got %h want %h", rd_data, exp); end
    swap();
    drive(0, 0, 0, 0, 0, 0, 3, 2, 1);
    exp = exp_q.pop_front();
    checks++; if (rd_data !== exp) begin failures++; $display("FAIL basic_rd: got %h want %h", rd_data, exp); end
    checks++; if (front_sel !== m_front) begin failures++; $display("FAIL basic_front_sel: got %b want %b", front_sel, m_front); end
    checks++; if (frame_count !== m_count) begin failures++; $display("FAIL basic_frame_count: got %0d want %0d", frame_count, m_count); end
  endtask

  task automatic test_hidden_until_swap();
    drive(1, 0, 0, 12'h123, 0, 0, 0, 0, 1);
    exp = exp_q.pop_front();
    checks++; if (rd_data !== exp) begin failures++; $display("FAIL hidden_same_cycle_rd: got %h want %h", rd_data, exp); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    exp = exp_q.pop_front();
    checks++; if (rd_data !== exp) begin failures++; $display("FAIL hidden_before_swap_rd: got %h want %h", rd_data, exp); end
    swap();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    exp = exp_q.pop_front();
    checks++; if (rd_data !== exp) begin failures++; $display("FAIL hidden_after_swap_rd: got %h want %h", rd_data, exp); end
  endtask

  task automatic test_drop_when_not_ready();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL drop_wr_ready_low: got %b want 0", wr_ready); end
    checks++; if (swap_pending !== 1'b1) begin failures++; $display("FAIL drop_swap_pending: got %b want 1", swap_pending); end
    drive(1, 5, 5, 12'hAAA, 1, 0, 0, 0, 0);
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL drop_wr_ready_still_low: got %b want 0", wr_ready); end
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL drop_wr_ready_after_vsync: got %b want 1", wr_ready); end
    checks++; if (swap_pending !== 1'b0) begin failures++; $display("FAIL drop_swap_pending_after_vsync: got %b want 0", swap_pending); end
    drive(0, 0, 0, 0, 0, 0, 5, 5, 1);
    exp = exp_q.pop_front();
    checks++; if (rd_data !== exp) begin failures++; $display("FAIL drop_rd_front: got %h want %h", rd_data, exp); end
    swap();
    drive(0, 0, 0, 0, 0, 0, 5, 5, 1);
    exp = exp_q.pop_front();
    checks++; if (rd_data !== exp) begin failures++; $display("FAIL drop_rd_other_bank: got %h want %h", rd_data, exp); end
  endtask

  task automatic test_same_cycle_done_vsync();
    bit front_before;
    front_before = front_sel;
    drive(0, 0, 0, 0, 1, 1, 0, 0, 0);
    checks++; if (front_sel !== front_before) begin failures++; $display("FAIL same_cycle_front_sel: got %b want %b", front_sel, front_before); end
    checks++; if (swap_pending !== 1'b1) begin failures++; $display("FAIL same_cycle_swap_pending: got %b want 1", swap_pending); end
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checks++; if (front_sel !== m_front) begin failures++; $display("FAIL same_cycle_next_vsync_front: got %b want %b", front_sel, m_front); end
    checks++; if (frame_count !== m_count) begin failures++; $display("FAIL same_cycle_frame_count: got %0d want %0d", frame_count, m_count); end
  endtask

  task automatic test_out_of_range();
    drive(1, 80, 0, 12'h777, 0, 0, 0, 0, 0);
    drive(1, 0, 60, 12'h777, 0, 0, 0, 0, 0);
    drive(1, 79, 59, 12'h5A5, 0, 0, 0, 0, 0);
    swap();
    drive(0, 0, 0, 0, 0, 0, 79, 59, 1);
    exp = exp_q.pop_front();
    checks++; if (rd_data !== exp) begin failures++; $display("FAIL range_rd_corner: got %h want %h", rd_data, exp); end
    drive(0, 0, 0, 0, 0, 0, 80, 59, 1);
    exp = exp_q.pop_front();
    checks++; if (rd_data !== exp) begin failures++; $display("FAIL range_rd_col80: got %h want %h", rd_data, exp); end
    drive(0, 0, 0, 0, 0, 0, 0, 60, 1);
    exp = exp_q.pop_front();
    checks++; if (rd_data !== exp) begin failures++; $display("FAIL range_rd_row60: got %h want %h", rd_data, exp); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    exp = exp_q.pop_front();
    checks++; if (rd_data !== exp) begin failures++; $display("FAIL range_rd_origin: got %h want %h", rd_data, exp); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1, 10 + i, 7, 12'(12'h300 + 12'(i * 17)), 0, 0, 9 + i, 7, 1);
      exp = exp_q.pop_front();
      checks++; if (rd_data !== exp) begin failures++; $display("FAIL b2b_wr_rd[%0d]: got %h want %h", i, rd_data, exp); end
    end
    swap();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 10 + i, 7, 1);
      exp = exp_q.pop_front();
      checks++; if (rd_data !== exp) begin failures++; $display("FAIL b2b_rd[%0d]: got %h want %h", i, rd_data, exp); end
    end
  endtask

  task automatic test_wrap_and_reset();
    apply_reset(0, 0);
    for (int i = 0; i < 255; i++) swap();
    checks++; if (frame_count !== m_count) begin failures++; $display("FAIL wrap_count_255: got %0d want %0d", frame_count, m_count); end
    swap();
    checks++; if (frame_count !== 8'd0) begin failures++; $display("FAIL wrap_count_0: got %0d want 0", frame_count); end
    checks++; if (front_sel !== 1'b0) begin failures++; $display("FAIL wrap_front_sel: got %b want 0", front_sel); end
    swap();
    drive(0, 0, 0, 0, 1, 0, 3, 2, 0);
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL midwait_wr_ready: got %b want 0", wr_ready); end
    apply_reset(3, 2);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL midwait_reset_wr_ready: got %b want 1", wr_ready); end
    checks++; if (swap_pending !== 1'b0) begin failures++; $display("FAIL midwait_reset_swap_pending: got %b want 0", swap_pending); end
    checks++; if (frame_count !== 8'd0) begin failures++; $display("FAIL midwait_reset_frame_count: got %0d want 0", frame_count); end
    checks++; if (rd_data !== 12'h000) begin failures++; $display("FAIL midwait_reset_rd_data: got %h want 000", rd_data); end
    checks++; if (front_sel !== 1'b0) begin failures++; $display("FAIL midwait_reset_front_sel: got %b want 0", front_sel); end
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    prefill();
    test_reset();
    test_basic_write_read();
    test_hidden_until_swap();
    test_drop_when_not_ready();
    test_same_cycle_done_vsync();
    test_out_of_range();
    test_back_to_back();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
